// File: rtl/cdc_pkg.sv
// Gray/binary conversion and width helpers shared by the async FIFO write and read controllers.
// Conversions work on 64-bit values; callers size-cast the result to their pointer width.
package cdc_pkg;

   function automatic logic [63:0] bin2gray(input logic [63:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [63:0] gray2bin(input logic [63:0] g);
      logic [63:0] b;
      b[63] = g[63];
      for (int i = 62; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus; latency P_STAGES edges, no flow control.
module cdc_sync_bus #(
   parameter int P_WIDTH  = 5,
   parameter int P_STAGES = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [P_WIDTH-1:0] i_dat,
   output logic [P_WIDTH-1:0] o_dat
);

   logic [P_WIDTH-1:0] sync_q [P_STAGES];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < P_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= i_dat;
         for (int i = 1; i < P_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign o_dat = sync_q[P_STAGES-1];

endmodule

// File: rtl/wr_ctrl_pack.sv
// Async FIFO write controller: packs P_RATIO units per word, strobes lanes combinationally,
// commits on the edge; full/level come from flops only, so a full FIFO drops units and flags overflow.
import cdc_pkg::*;

module wr_ctrl_pack #(
   parameter int P_ADDR_WIDTH   = 4,
   parameter int P_RATIO        = 4,
   parameter int P_AFULL_THRESH = 12,
   parameter int P_SYNC_STAGES  = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_inc,
   input  logic                    i_flush,
   input  logic [P_ADDR_WIDTH:0]   i_rd_ptr_gray,
   output logic [P_RATIO-1:0]      o_lane_en,
   output logic [P_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [P_ADDR_WIDTH:0]   o_wr_ptr_gray,
   output logic                    o_full,
   output logic                    o_afull,
   output logic [P_ADDR_WIDTH:0]   o_level,
   output logic                    o_overflow
);

   localparam int L_PTR_W  = P_ADDR_WIDTH + 1;
   localparam int L_SLOT_W = (P_RATIO > 1) ? clog2(P_RATIO) : 1;
   localparam int L_DEPTH  = 1 << P_ADDR_WIDTH;

   logic [L_SLOT_W-1:0] slot_q, slot_d;
   logic [L_PTR_W-1:0]  wr_bin_q, wr_bin_d;
   logic [L_PTR_W-1:0]  wr_gray_q, wr_gray_d;
   logic                ovf_q, ovf_d;
   logic [L_PTR_W-1:0]  rd_gray_sync, rd_bin, level;
   logic                full, accept, last_slot, commit;

   cdc_sync_bus #(
      .P_WIDTH  (L_PTR_W),
      .P_STAGES (P_SYNC_STAGES)
   ) u_rd_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_dat (i_rd_ptr_gray),
      .o_dat (rd_gray_sync)
   );

   assign rd_bin = L_PTR_W'(gray2bin(64'(rd_gray_sync)));
   assign level  = wr_bin_q - rd_bin;
   assign full   = (level == L_PTR_W'(L_DEPTH));

   // Gating with reset keeps the lane strobes quiet while reset is held.
   assign accept    = i_inc & ~full & ~i_rst;
   assign last_slot = (slot_q == L_SLOT_W'(P_RATIO - 1));

   always_comb begin
      slot_d = slot_q;
      commit = 1'b0;
      if (accept) begin
         if (last_slot | i_flush) begin
            commit = 1'b1;
            slot_d = '0;
         end else begin
            slot_d = slot_q + L_SLOT_W'(1);
         end
      end else if (i_flush && (slot_q != '0)) begin
         commit = 1'b1;
         slot_d = '0;
      end
   end

   assign wr_bin_d  = wr_bin_q + L_PTR_W'(commit);
   assign wr_gray_d = L_PTR_W'(bin2gray(64'(wr_bin_d)));
   assign ovf_d     = ovf_q | (i_inc & full);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         slot_q    <= '0;
         wr_bin_q  <= '0;
         wr_gray_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         wr_bin_q  <= wr_bin_d;
         wr_gray_q <= wr_gray_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_lane_en     = accept ? (P_RATIO'(1) << slot_q) : '0;
   assign o_wr_addr     = wr_bin_q[P_ADDR_WIDTH-1:0];
   assign o_wr_ptr_gray = wr_gray_q;
   assign o_full        = full;
   assign o_afull       = (level >= L_PTR_W'(P_AFULL_THRESH));
   assign o_level       = level;
   assign o_overflow    = ovf_q;

endmodule

// File: doc/wr_ctrl_pack.md
Name: wr_ctrl_pack

Overview:
- Parametrised write-side controller for the async FIFO; successor of the many-to-one write controller.
- Packs P_RATIO narrow data units into one FIFO word and drives per-lane write enables to the RAM.
- Synchronises the Gray-coded read pointer in from the read domain and publishes a registered Gray write pointer.
- Adds wrap-bit full detection, almost-full, fill level, sticky overflow, and a flush that commits a partially filled word.

Parameters:
- P_ADDR_WIDTH, 4: FIFO depth is 2^P_ADDR_WIDTH words. Pointers are P_ADDR_WIDTH+1 bits (MSB is the wrap bit).
- P_RATIO, 4: units per word. Power of two, 1..64.
- P_AFULL_THRESH, 12: o_afull asserts when level >= this. Range 1..2^P_ADDR_WIDTH.
- P_SYNC_STAGES, 2: flop stages on the incoming read pointer. Minimum 2.

Ports:
- i_clk  in  1  write-domain clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_inc  in  1  write one unit this cycle.
- i_flush  in  1  commit the current partial word.
- i_rd_ptr_gray  in  P_ADDR_WIDTH+1  Gray read pointer from the read domain (asynchronous).
- o_lane_en  out  P_RATIO  one-hot unit-lane write strobe to the RAM.
- o_wr_addr  out  P_ADDR_WIDTH  RAM word address (low bits of the binary write pointer).
- o_wr_ptr_gray  out  P_ADDR_WIDTH+1  registered Gray write pointer to the read domain.
- o_full  out  1  no free word.
- o_afull  out  1  level >= P_AFULL_THRESH.
- o_level  out  P_ADDR_WIDTH+1  committed words not yet read, as seen by the write side.
- o_overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (asynchronous, no clock edge needed):
  - binary pointer, Gray pointer, slot counter and sync flops all clear to 0.
  - o_overflow = 0; all outputs = 0.
- Accept condition: accept = i_inc & ~o_full.
- o_lane_en = accept ? onehot(slot) : 0. Combinational; the data lands at o_wr_addr in the same cycle.
- Slot counter, per clock edge:
  - accept with slot == P_RATIO-1: slot <= 0, pointer increments (commit).
  - accept otherwise: slot <= slot+1.
  - i_flush & ~accept & slot != 0: commit, slot <= 0.
  - i_flush & accept: the unit is written, then commit, slot <= 0, regardless of slot value.
  - i_flush & ~accept & slot == 0: no operation.
  - A flush and a last-slot accept in the same cycle produce exactly one increment.
- Unused lanes of a flushed word are never strobed; their contents are don't-care for the reader.
- Pointer: binary increment, modulo 2^(P_ADDR_WIDTH+1). o_wr_ptr_gray is registered from bin2gray(next pointer), so it updates on the same edge as the binary pointer. Exactly one bit changes per commit.
- Read-pointer sync:
  - i_rd_ptr_gray passes through a P_SYNC_STAGES flop chain.
  - The last stage is converted combinationally with gray2bin to rd_bin.
- Level and flags:
  - o_level = wr_bin - rd_bin, modulo 2^(P_ADDR_WIDTH+1).
  - o_full = (o_level == 2^P_ADDR_WIDTH).
  - o_afull = (o_level >= P_AFULL_THRESH).
  - All three are functions of flops only; there is no input-to-output combinational path.
- Timing:
  - A commit that fills the FIFO asserts o_full in the cycle following that edge.
  - A read-pointer change deasserts o_full after P_SYNC_STAGES edges. This is pessimistic and never optimistic.
- Overflow: i_inc & o_full drops the unit (no lane strobe, no slot change) and sets o_overflow. It clears only on reset.
- Partial word while full: cannot occur. o_full is tested before every unit, so a word in progress always owns a free address.
- P_RATIO = 1: slot is a constant 0, every accept commits, and flush is a no-op.

Decomposition:
- Package cdc_pkg:
  - functions bin2gray, gray2bin, clog2.
  - localparams L_PTR_W = P_ADDR_WIDTH+1, L_SLOT_W = max(1, clog2(P_RATIO)), L_DEPTH = 2^P_ADDR_WIDTH.
- Sub-module cdc_sync_bus (width and stage count parametrised; async reset; flop chain only). Instantiated once for the read pointer. Reused later by the read-side controller.

Test Plan:
- Packing (A=4, R=4, read pointer held at 0): 8 consecutive i_inc -> o_lane_en 0001, 0010, 0100, 1000, repeated; o_wr_ptr_gray 00000 -> 00001 -> 00011; o_level 0 -> 1 -> 2.
- Full and overflow (read pointer held at 0):
  - 64 i_inc -> o_full = 1 and o_level = 16 after the 64th edge; o_afull rose at the commit making level 12.
  - A 65th i_inc -> o_lane_en = 0, pointer unchanged, o_overflow = 1 and stays 1.
- Flush:
  - 3 incs then i_flush -> pointer 1, slot 0.
  - Lone i_flush at slot 0 -> no change.
  - At slot 1, i_inc & i_flush together -> lane 0010 strobed, pointer +1, slot 0.
- Release: at full, drive i_rd_ptr_gray = 00001 -> o_full deasserts after exactly 2 edges (P_SYNC_STAGES = 2); o_level = 15.
- Wrap (reader tracking the writer, 40 word commits) -> o_wr_ptr_gray steps 10001 (bin 30) -> 10000 (bin 31) -> 00000; o_level never exceeds 16 and never underflows.
- Async reset: assert i_rst mid-cycle at slot 2 with o_overflow = 1 -> all outputs 0 before the next edge; the first i_inc after release strobes lane 0001.
